adc_serial_capture: RTL and testbench

//  Parametrised serial-ADC capture engine for AD7091R-class converters (CONVST/CS/SCLK/SDO). One

---
 rtl/adc_serial_capture_if.sv | 24 ++
 rtl/adc_serial_capture.sv | 181 ++++++++++++++++++
 tb/tb_adc_serial_capture.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_serial_capture_if.sv
// Result stream of the serial ADC capture engine: one packed word holding
// every channel's sample, qualified by a valid/ready handshake.
interface adc_serial_capture_if #(
   parameter int DATA_W = 12,
   parameter int NCH    = 2
);
   logic [NCH*DATA_W-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   // Capture engine side: produces samples.
   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   // Acquisition side: consumes samples.
   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/adc_serial_capture.sv
// Serial ADC capture engine for AD7091R-class converters. One shared
// CONVST_N/CS_N/SCLK set drives NCH converters in lock-step; each converter
// returns its sample MSB-first on its own SDO line. Frames are started by a
// single-shot request or by an internal period counter, and the combined
// result is presented on a valid/ready port with overrun reporting.
module adc_serial_capture #(
   parameter int DATA_W    = 12,
   parameter int NCH       = 2,
   parameter int CONV_LO   = 1,
   parameter int CONV_WAIT = 8,
   parameter int SCLK_HALF = 1,
   parameter int PERIOD    = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  start,
   input  logic                  auto_en,
   output logic                  convst_n_o,
   output logic                  cs_n_o,
   output logic                  sclk_o,
   input  logic [NCH-1:0]        sdo_i,
   adc_serial_capture_if.master  res,
   output logic                  overrun,
   output logic                  busy
);

   // Phase timer covers the longest of the three programmable intervals.
   localparam int TMAX0  = (CONV_LO > CONV_WAIT) ? CONV_LO : CONV_WAIT;
   localparam int TMAX   = (TMAX0 > SCLK_HALF) ? TMAX0 : SCLK_HALF;
   localparam int TCNT_W = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam int PCNT_W = $clog2(PERIOD);

   localparam logic [TCNT_W-1:0] T_CONV   = TCNT_W'(CONV_LO - 1);
   localparam logic [TCNT_W-1:0] T_WAIT   = TCNT_W'(CONV_WAIT - 1);
   localparam logic [TCNT_W-1:0] T_HALF   = TCNT_W'(SCLK_HALF - 1);
   localparam logic [TCNT_W-1:0] T_ONE    = TCNT_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W);
   localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
   localparam logic [PCNT_W-1:0] P_RELOAD = PCNT_W'(PERIOD - 1);
   localparam logic [PCNT_W-1:0] P_ONE    = PCNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_WAIT,
      S_SETUP,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t              state;
   logic [TCNT_W-1:0]   tcnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [PCNT_W-1:0]   pcnt;
   logic [DATA_W-1:0]   shreg [NCH];
   logic [NCH*DATA_W-1:0] shreg_flat;
   logic                tick_end;
   logic                trig;
   logic                shift_en;

   assign tick_end = (tcnt == '0);
   assign trig     = start || (auto_en && (pcnt == '0));
   assign busy     = (state != S_IDLE);

   // A bit is taken on exactly the enabled edge that drives SCLK high: the
   // SETUP exit, or the end of a low half-period that still has bits to go.
   assign shift_en = en && tick_end &&
                     ((state == S_SETUP) ||
                      ((state == S_SHIFT) && !sclk_o && (bit_cnt != BIT_LAST)));

   // Per-channel shift registers; the frame always overwrites every bit, so
   // they need no reset.
   always_ff @(posedge clk) begin
      if (shift_en) begin
         for (int k = 0; k < NCH; k++) begin
            shreg[k] <= {shreg[k][DATA_W-2:0], sdo_i[k]};
         end
      end
   end

   // Pack the channel registers into the output word layout.
   always_comb begin
      shreg_flat = '0;
      for (int k = 0; k < NCH; k++) begin
         shreg_flat[k*DATA_W +: DATA_W] = shreg[k];
      end
   end

   // Frame sequencer, period counter, pin drivers and result handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         tcnt          <= '0;
         bit_cnt       <= '0;
         pcnt          <= '0;
         convst_n_o    <= 1'b1;
         cs_n_o        <= 1'b1;
         sclk_o        <= 1'b0;
         res.out_data  <= '0;
         res.out_valid <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         overrun <= 1'b0;
         // The consumer side runs regardless of the clock enable.
         if (res.out_valid && res.out_ready) begin
            res.out_valid <= 1'b0;
         end
         if (en) begin
            if (pcnt != '0) begin
               pcnt <= pcnt - P_ONE;
            end
            case (state)
               S_IDLE: begin
                  if (trig) begin
                     state      <= S_CONV;
                     convst_n_o <= 1'b0;
                     tcnt       <= T_CONV;
                     pcnt       <= P_RELOAD;
                  end
               end
               S_CONV: begin
                  if (tick_end) begin
                     state      <= S_WAIT;
                     convst_n_o <= 1'b1;
                     tcnt       <= T_WAIT;
                  end else begin
                     tcnt <= tcnt - T_ONE;
                  end
               end
               S_WAIT: begin
                  if (tick_end) begin
                     state  <= S_SETUP;
                     cs_n_o <= 1'b0;
                     tcnt   <= T_HALF;
                  end else begin
                     tcnt <= tcnt - T_ONE;
                  end
               end
               S_SETUP: begin
                  if (tick_end) begin
                     state   <= S_SHIFT;
                     sclk_o  <= 1'b1;
                     tcnt    <= T_HALF;
                     bit_cnt <= BIT_ONE;
                  end else begin
                     tcnt <= tcnt - T_ONE;
                  end
               end
               S_SHIFT: begin
                  if (!tick_end) begin
                     tcnt <= tcnt - T_ONE;
                  end else if (sclk_o) begin
                     sclk_o <= 1'b0;
                     tcnt   <= T_HALF;
                  end else if (bit_cnt == BIT_LAST) begin
                     state  <= S_DONE;
                     cs_n_o <= 1'b1;
                  end else begin
                     sclk_o  <= 1'b1;
                     tcnt    <= T_HALF;
                     bit_cnt <= bit_cnt + BIT_ONE;
                  end
               end
               S_DONE: begin
                  // A result still pending and not taken this cycle is lost.
                  state         <= S_IDLE;
                  res.out_data  <= shreg_flat;
                  res.out_valid <= 1'b1;
                  overrun       <= res.out_valid && !res.out_ready;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture: two instances (PERIOD 64 and 40),
// each fed by a small converter model that presents its word MSB-first and
// advances one bit after every SCLK rise.
module tb_adc_serial_capture;
   localparam int DW = 12;
   localparam int NC = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          en_a, start_a, auto_a, cv_a, cs_a, sc_a, ov_a, busy_a;
   logic [NC-1:0] sdo_a;
   logic          en_b, start_b, auto_b, cv_b, cs_b, sc_b, ov_b, busy_b;
   logic [NC-1:0] sdo_b;

   adc_serial_capture_if #(.DATA_W(DW), .NCH(NC)) res_a ();
   adc_serial_capture_if #(.DATA_W(DW), .NCH(NC)) res_b ();

   adc_serial_capture #(.DATA_W(DW), .NCH(NC), .CONV_LO(1), .CONV_WAIT(8),
                        .SCLK_HALF(1), .PERIOD(64)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .start(start_a), .auto_en(auto_a),
      .convst_n_o(cv_a), .cs_n_o(cs_a), .sclk_o(sc_a), .sdo_i(sdo_a),
      .res(res_a), .overrun(ov_a), .busy(busy_a));

   adc_serial_capture #(.DATA_W(DW), .NCH(NC), .CONV_LO(1), .CONV_WAIT(8),
                        .SCLK_HALF(1), .PERIOD(40)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .start(start_b), .auto_en(auto_b),
      .convst_n_o(cv_b), .cs_n_o(cs_b), .sclk_o(sc_b), .sdo_i(sdo_b),
      .res(res_b), .overrun(ov_b), .busy(busy_b));

   // Converter models
   logic [DW-1:0] w0_a, w1_a, w0_b, w1_b;
   int   idx_a = 0, rises_a = 0, cslow_a = 0;
   int   idx_b = 0, rises_b = 0, cslow_b = 0;
   logic scp_a = 1'b0, scp_b = 1'b0;

   assign sdo_a = (idx_a < DW) ? {w1_a[DW-1-idx_a], w0_a[DW-1-idx_a]} : 2'b00;
   assign sdo_b = (idx_b < DW) ? {w1_b[DW-1-idx_b], w0_b[DW-1-idx_b]} : 2'b00;

   always @(negedge clk) begin
      if (cs_a) idx_a <= 0;
      else begin
         cslow_a <= cslow_a + 1;
         if (sc_a && !scp_a) begin
            idx_a   <= idx_a + 1;
            rises_a <= rises_a + 1;
         end
      end
      scp_a <= sc_a;
   end

   always @(negedge clk) begin
      if (cs_b) idx_b <= 0;
      else begin
         cslow_b <= cslow_b + 1;
         if (sc_b && !scp_b) begin
            idx_b   <= idx_b + 1;
            rises_b <= rises_b + 1;
         end
      end
      scp_b <= sc_b;
   end

   int vecs = 0;
   int miss = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse start on A and count edges until out_valid (bounded).
   task automatic run_frame_a(output int lat);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      lat = 0;
      while (!res_a.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, r0, c0, falls, bad, ovs, last, ovc, ov_at;
      logic prev_cv;

      rst_n = 1'b0;
      en_a = 1'b1; start_a = 1'b0; auto_a = 1'b0; res_a.out_ready = 1'b0;
      en_b = 1'b1; start_b = 1'b0; auto_b = 1'b0; res_b.out_ready = 1'b0;
      w0_a = 12'hA5C; w1_a = 12'h3F1; w0_b = 12'h111; w1_b = 12'h222;
      repeat (3) @(negedge clk);
      chk("reset pins", {cv_a, cs_a, sc_a, busy_a, ov_a, res_a.out_valid}, 6'b110000);
      chk("reset data", res_a.out_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-shot frame with default timing
      r0 = rises_a; c0 = cslow_a;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("t1 convst low", cv_a, 0);
      chk("t1 busy", busy_a, 1);
      lat = 0;
      while (!res_a.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("t1 latency", lat, 35);
      chk("t1 data", res_a.out_data, 24'h3F1A5C);
      chk("t1 sclk pulses", rises_a - r0, 12);
      chk("t1 cs low cycles", cslow_a - c0, 25);
      chk("t1 overrun", ov_a, 0);
      res_a.out_ready = 1'b1;
      @(negedge clk);
      res_a.out_ready = 1'b0;
      chk("t1 consumed", res_a.out_valid, 0);

      // Ready coincident with DONE while a result is pending
      w0_a = 12'h123; w1_a = 12'h456;
      run_frame_a(lat);
      chk("t4 first data", res_a.out_data, 24'h456123);
      w0_a = 12'h789; w1_a = 12'hABC;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (34) @(negedge clk);
      res_a.out_ready = 1'b1;
      @(negedge clk);
      res_a.out_ready = 1'b0;
      chk("t4 valid kept", res_a.out_valid, 1);
      chk("t4 no overrun", ov_a, 0);
      chk("t4 new data", res_a.out_data, 24'hABC789);
      @(negedge clk);
      chk("t4 data stable", res_a.out_data, 24'hABC789);
      res_a.out_ready = 1'b1;
      @(negedge clk);
      res_a.out_ready = 1'b0;

      // Clock enable toggling every cycle
      w0_a = 12'h0F0; w1_a = 12'h70E;
      r0 = rises_a;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      lat = 0;
      while (!res_a.out_valid && lat < 300) begin
         en_a = (lat % 2 == 1);
         @(negedge clk);
         lat++;
      end
      en_a = 1'b1;
      chk("t5 latency", lat, 70);
      chk("t5 data", res_a.out_data, 24'h70E0F0);
      chk("t5 sclk pulses", rises_a - r0, 12);

      // Reset during SHIFT bit 5 (previous result left pending)
      w0_a = 12'hFFF; w1_a = 12'hFFF;
      r0 = rises_a;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (18) @(negedge clk);
      #1;
      chk("t6 in bit5", {sc_a, cs_a}, 2'b10);
      chk("t6 bits so far", rises_a - r0, 5);
      rst_n = 1'b0;
      #1;
      chk("t6 pins idle", {cv_a, cs_a, sc_a, busy_a}, 4'b1100);
      chk("t6 valid cleared", res_a.out_valid, 0);
      chk("t6 data cleared", res_a.out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      w0_a = 12'h555; w1_a = 12'hAAA;
      run_frame_a(lat);
      chk("t6 restart latency", lat, 35);
      chk("t6 restart data", res_a.out_data, 24'hAAA555);
      res_a.out_ready = 1'b1;
      @(negedge clk);
      res_a.out_ready = 1'b0;
      repeat (70) @(negedge clk);

      // Auto mode, PERIOD 64, consumer always ready
      w0_a = 12'h1E3; w1_a = 12'h2C4;
      res_a.out_ready = 1'b1;
      auto_a = 1'b1;
      falls = 0; bad = 0; ovs = 0; last = -1;
      prev_cv = cv_a;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (prev_cv && !cv_a) begin
            falls++;
            if (last >= 0 && (i - last) != 64) bad++;
            last = i;
         end
         prev_cv = cv_a;
         if (ov_a) ovs++;
      end
      auto_a = 1'b0;
      chk("t2 frames", falls, 4);
      chk("t2 bad intervals", bad, 0);
      chk("t2 overruns", ovs, 0);
      chk("t2 data", res_a.out_data, 24'h2C41E3);
      repeat (70) @(negedge clk);
      chk("t2 stopped", {busy_a, cv_a}, 2'b01);
      res_a.out_ready = 1'b0;

      // Auto mode, PERIOD 40, consumer never ready
      auto_b = 1'b1;
      ovc = 0; ov_at = -1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (i == 36) begin
            chk("t3 frame1 data", res_b.out_data, 24'h222111);
            w0_b = 12'h333; w1_b = 12'h444;
         end
         if (ov_b) begin
            ovc++;
            ov_at = i;
         end
      end
      auto_b = 1'b0;
      chk("t3 overrun count", ovc, 1);
      chk("t3 overrun edge", ov_at, 75);
      chk("t3 valid", res_b.out_valid, 1);
      chk("t3 frame2 data", res_b.out_data, 24'h444333);
      repeat (50) @(negedge clk);
      chk("t3 no third frame", busy_b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
